// File: rtl/led_slot_scheduler.sv
// Frame scheduler for the pulse-oximeter front end: alternates RED/IR slots, blanks
// the ADC while the analog path settles, then averages 2^SAMPLE_LOG2 samples per slot.
module led_slot_scheduler #(
    parameter int SETTLE_CYCLES = 2,
    parameter int SAMPLE_LOG2   = 3
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cfg_valid,
    input  logic [6:0] red_dc,
    input  logic [3:0] red_pga,
    input  logic [6:0] ir_dc,
    input  logic [3:0] ir_pga,
    input  logic [7:0] ADC,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic       sample_valid,
    output logic       sample_is_ir,
    output logic       busy
);
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RED_SETTLE = 3'd1;
    localparam logic [2:0] ST_RED_SAMPLE = 3'd2;
    localparam logic [2:0] ST_IR_SETTLE  = 3'd3;
    localparam logic [2:0] ST_IR_SAMPLE  = 3'd4;

    localparam int ACC_W = 8 + SAMPLE_LOG2;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'((1 << SAMPLE_LOG2) - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic             cfg_loaded_q, cfg_loaded_d;
    logic [6:0]       sh_red_dc_q, sh_red_dc_d, sh_ir_dc_q, sh_ir_dc_d;
    logic [3:0]       sh_red_pga_q, sh_red_pga_d, sh_ir_pga_q, sh_ir_pga_d;
    logic [6:0]       snap_red_dc_q, snap_red_dc_d, snap_ir_dc_q, snap_ir_dc_d;
    logic [3:0]       snap_red_pga_q, snap_red_pga_d, snap_ir_pga_q, snap_ir_pga_d;
    logic             led_red_q, led_red_d, led_ir_q, led_ir_d;
    logic [6:0]       dc_q, dc_d;
    logic [3:0]       pga_q, pga_d;
    logic [7:0]       red_val_q, red_val_d, ir_val_q, ir_val_d;
    logic             sv_q, sv_d, sir_q, sir_d, busy_q, busy_d;
    logic             take_snap;

    // The accumulated sum includes the current sample so the final edge can publish directly.
    assign acc_sum = acc_q + ACC_W'(ADC);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        cfg_loaded_d   = cfg_loaded_q;
        sh_red_dc_d    = sh_red_dc_q;
        sh_red_pga_d   = sh_red_pga_q;
        sh_ir_dc_d     = sh_ir_dc_q;
        sh_ir_pga_d    = sh_ir_pga_q;
        snap_red_dc_d  = snap_red_dc_q;
        snap_red_pga_d = snap_red_pga_q;
        snap_ir_dc_d   = snap_ir_dc_q;
        snap_ir_pga_d  = snap_ir_pga_q;
        red_val_d      = red_val_q;
        ir_val_d       = ir_val_q;
        dc_d           = dc_q;
        pga_d          = pga_q;
        sv_d           = 1'b0;
        sir_d          = 1'b0;
        take_snap      = 1'b0;

        if (cfg_valid) begin
            cfg_loaded_d = 1'b1;
            sh_red_dc_d  = red_dc;
            sh_red_pga_d = red_pga;
            sh_ir_dc_d   = ir_dc;
            sh_ir_pga_d  = ir_pga;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && (cfg_loaded_q || cfg_valid)) begin
                    state_d   = ST_RED_SETTLE;
                    take_snap = 1'b1;
                end
            end
            ST_RED_SETTLE: begin
                if (!enable)                  state_d = ST_IDLE;
                else if (cnt_q == SETTLE_LAST) state_d = ST_RED_SAMPLE;
                else                           cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_RED_SAMPLE: begin
                // Publishing the result wins over an abort on the final sample edge.
                if (cnt_q == SAMPLE_LAST) begin
                    red_val_d = acc_sum[SAMPLE_LOG2 +: 8];
                    sv_d      = 1'b1;
                    state_d   = enable ? ST_IR_SETTLE : ST_IDLE;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IR_SETTLE: begin
                if (!enable)                  state_d = ST_IDLE;
                else if (cnt_q == SETTLE_LAST) state_d = ST_IR_SAMPLE;
                else                           cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_IR_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    ir_val_d = acc_sum[SAMPLE_LOG2 +: 8];
                    sv_d     = 1'b1;
                    sir_d    = 1'b1;
                    if (enable) begin
                        state_d   = ST_RED_SETTLE;
                        take_snap = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            acc_d = '0;
        end

        // Frame snapshot; a strobe on the frame-start edge bypasses the shadow registers.
        if (take_snap) begin
            snap_red_dc_d  = cfg_valid ? red_dc  : sh_red_dc_q;
            snap_red_pga_d = cfg_valid ? red_pga : sh_red_pga_q;
            snap_ir_dc_d   = cfg_valid ? ir_dc   : sh_ir_dc_q;
            snap_ir_pga_d  = cfg_valid ? ir_pga  : sh_ir_pga_q;
        end

        if (state_d == ST_RED_SETTLE && state_q != ST_RED_SETTLE) begin
            dc_d  = snap_red_dc_d;
            pga_d = snap_red_pga_d;
        end else if (state_d == ST_IR_SETTLE && state_q != ST_IR_SETTLE) begin
            dc_d  = snap_ir_dc_d;
            pga_d = snap_ir_pga_d;
        end

        led_red_d = (state_d == ST_RED_SETTLE) || (state_d == ST_RED_SAMPLE);
        led_ir_d  = (state_d == ST_IR_SETTLE)  || (state_d == ST_IR_SAMPLE);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            acc_q          <= '0;
            cfg_loaded_q   <= 1'b0;
            sh_red_dc_q    <= '0;
            sh_red_pga_q   <= '0;
            sh_ir_dc_q     <= '0;
            sh_ir_pga_q    <= '0;
            snap_red_dc_q  <= '0;
            snap_red_pga_q <= '0;
            snap_ir_dc_q   <= '0;
            snap_ir_pga_q  <= '0;
            led_red_q      <= 1'b0;
            led_ir_q       <= 1'b0;
            dc_q           <= '0;
            pga_q          <= '0;
            red_val_q      <= '0;
            ir_val_q       <= '0;
            sv_q           <= 1'b0;
            sir_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            cfg_loaded_q   <= cfg_loaded_d;
            sh_red_dc_q    <= sh_red_dc_d;
            sh_red_pga_q   <= sh_red_pga_d;
            sh_ir_dc_q     <= sh_ir_dc_d;
            sh_ir_pga_q    <= sh_ir_pga_d;
            snap_red_dc_q  <= snap_red_dc_d;
            snap_red_pga_q <= snap_red_pga_d;
            snap_ir_dc_q   <= snap_ir_dc_d;
            snap_ir_pga_q  <= snap_ir_pga_d;
            led_red_q      <= led_red_d;
            led_ir_q       <= led_ir_d;
            dc_q           <= dc_d;
            pga_q          <= pga_d;
            red_val_q      <= red_val_d;
            ir_val_q       <= ir_val_d;
            sv_q           <= sv_d;
            sir_q          <= sir_d;
            busy_q         <= busy_d;
        end
    end

    assign LED_RED       = led_red_q;
    assign LED_IR        = led_ir_q;
    assign DC_Comp       = dc_q;
    assign PGA_Gain      = pga_q;
    assign RED_ADC_Value = red_val_q;
    assign IR_ADC_Value  = ir_val_q;
    assign sample_valid  = sv_q;
    assign sample_is_ir  = sir_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_led_slot_scheduler.sv
// Directed bench for led_slot_scheduler with S=2, N=8 (20-cycle frames).
module tb_led_slot_scheduler;
    logic       CLK = 1'b0;
    logic       rst_n;
    logic       enable, cfg_valid;
    logic [6:0] red_dc, ir_dc;
    logic [3:0] red_pga, ir_pga;
    logic [7:0] ADC;
    logic       LED_RED, LED_IR, sample_valid, sample_is_ir, busy;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic [7:0] RED_ADC_Value, IR_ADC_Value;

    int checks = 0;
    int errors = 0;

    led_slot_scheduler #(.SETTLE_CYCLES(2), .SAMPLE_LOG2(3)) dut (
        .CLK(CLK), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid),
        .red_dc(red_dc), .red_pga(red_pga), .ir_dc(ir_dc), .ir_pga(ir_pga),
        .ADC(ADC), .LED_RED(LED_RED), .LED_IR(LED_IR), .DC_Comp(DC_Comp),
        .PGA_Gain(PGA_Gain), .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
        .sample_valid(sample_valid), .sample_is_ir(sample_is_ir), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [6:0] rdc;
        logic [3:0] rpga;
        logic [6:0] idc;
        logic [3:0] ipga;
        int         rbase, rstep, ibase, istep;
        logic [7:0] exp_red, exp_ir;
    } vec_t;

    vec_t tbl[4];

    function automatic logic [15:0] mk(input bit lr, input bit li, input logic [6:0] dc,
                                       input logic [3:0] pga, input bit sv, input bit si,
                                       input bit b);
        return {lr, li, dc, pga, sv, si, b};
    endfunction

    function automatic logic [15:0] cur_vec();
        return {LED_RED, LED_IR, DC_Comp, PGA_Gain, sample_valid, sample_is_ir, busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One frame from its start edge; stop_mode 1 drops enable, 2 asserts async reset at stop_at.
    task automatic do_frame(input logic [6:0] rdc, input logic [3:0] rpga,
                            input logic [6:0] idc, input logic [3:0] ipga,
                            input int rbase, input int rstep, input int ibase, input int istep,
                            input bit prev_ir, input logic [7:0] prev_ir_val,
                            input logic [7:0] exp_red, input int stop_at, input int stop_mode,
                            input int cfg_at, input logic [6:0] cfg_rdc);
        bit red_ph, sv, si;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            red_ph = (c <= 10);
            sv     = (c == 11) || (c == 1 && prev_ir);
            si     = (c == 1 && prev_ir);
            chk($sformatf("frame_c%0d", c), 32'(cur_vec()),
                32'(mk(red_ph, !red_ph, red_ph ? rdc : idc, red_ph ? rpga : ipga, sv, si, 1'b1)));
            if (c == 1 && prev_ir) chk("ir_value", 32'(IR_ADC_Value), 32'(prev_ir_val));
            if (c == 11) chk("red_value", 32'(RED_ADC_Value), 32'(exp_red));
            cfg_valid = (c == cfg_at);
            if (c == cfg_at) red_dc = cfg_rdc;
            if (c >= 3 && c <= 10)  ADC = 8'(rbase + rstep * (c - 3));
            else if (c >= 13)       ADC = 8'(ibase + istep * (c - 13));
            else                    ADC = 8'd255;
            if (c == stop_at) begin
                if (stop_mode == 1) begin
                    enable = 1'b0;
                end else begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("async_reset_vec", 32'(cur_vec()), 32'h0);
                    chk("async_reset_vals", {16'h0, RED_ADC_Value, IR_ADC_Value}, 32'h0);
                end
                break;
            end
        end
        $display("frame red=%0d/%0d ir=%0d/%0d stop_at=%0d mode=%0d checks=%0d errors=%0d",
                 rdc, rpga, idc, ipga, stop_at, stop_mode, checks, errors);
    endtask

    initial begin
        tbl[0] = '{7'd40,  4'd5,  7'd90,  4'd9,  100, 0, 200, 0, 8'd100, 8'd200};
        tbl[1] = '{7'd12,  4'd3,  7'd100, 4'd15, 0,   1, 255, 0, 8'd3,   8'd255};
        tbl[2] = '{7'd127, 4'd15, 7'd1,   4'd1,  10,  3, 200, 7, 8'd20,  8'd224};
        tbl[3] = '{7'd33,  4'd7,  7'd66,  4'd2,  1,   0, 0,   0, 8'd1,   8'd0};

        rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        red_dc = '0; red_pga = '0; ir_dc = '0; ir_pga = '0; ADC = '0;
        repeat (2) @(negedge CLK);
        chk("reset_vec", 32'(cur_vec()), 32'h0);
        chk("reset_vals", {16'h0, RED_ADC_Value, IR_ADC_Value}, 32'h0);
        rst_n = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("idle_no_cfg", 32'(cur_vec()), 32'h0);
        end

        // Back-to-back frames; each new config arrives on its frame-start edge.
        for (int i = 0; i < 4; i++) begin
            red_dc = tbl[i].rdc; red_pga = tbl[i].rpga;
            ir_dc  = tbl[i].idc; ir_pga  = tbl[i].ipga;
            cfg_valid = 1'b1;
            do_frame(tbl[i].rdc, tbl[i].rpga, tbl[i].idc, tbl[i].ipga,
                     tbl[i].rbase, tbl[i].rstep, tbl[i].ibase, tbl[i].istep,
                     i > 0, (i > 0) ? tbl[(i > 0) ? i - 1 : 0].exp_ir : 8'd0,
                     tbl[i].exp_red, (i == 3) ? 20 : 0, 1, 0, 7'd0);
        end
        @(negedge CLK);
        chk("stop_ir_strobe", 32'(cur_vec()), 32'(mk(1'b0, 1'b0, 7'd66, 4'd2, 1'b1, 1'b1, 1'b0)));
        chk("stop_vals", {16'h0, RED_ADC_Value, IR_ADC_Value}, {16'h0, 8'd1, 8'd0});
        @(negedge CLK);
        chk("stop_idle", 32'(cur_vec()), 32'(mk(1'b0, 1'b0, 7'd66, 4'd2, 1'b0, 1'b0, 1'b0)));

        // Mid-frame config change only takes effect on the following frame.
        enable = 1'b1;
        do_frame(7'd33, 4'd7, 7'd66, 4'd2, 50, 0, 70, 0, 1'b0, 8'd0, 8'd50, 0, 0, 5, 7'd60);
        // Abort on the 4th RED sample cycle.
        do_frame(7'd60, 4'd7, 7'd66, 4'd2, 255, 0, 0, 0, 1'b1, 8'd70, 8'd0, 6, 1, 0, 7'd0);
        @(negedge CLK);
        chk("abort_vec", 32'(cur_vec()), 32'(mk(1'b0, 1'b0, 7'd60, 4'd7, 1'b0, 1'b0, 1'b0)));
        chk("abort_vals", {16'h0, RED_ADC_Value, IR_ADC_Value}, {16'h0, 8'd50, 8'd70});

        // Restart after abort, then async reset in the middle of IR sampling.
        enable = 1'b1;
        do_frame(7'd60, 4'd7, 7'd66, 4'd2, 8, 0, 9, 0, 1'b0, 8'd0, 8'd8, 15, 2, 0, 7'd0);
        @(negedge CLK);
        chk("reset_hold_vec", 32'(cur_vec()), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post_reset_no_cfg", 32'(cur_vec()), 32'h0);
        end

        // Stop on the final RED sample edge: result is still published.
        red_dc = 7'd20; red_pga = 4'd4; ir_dc = 7'd30; ir_pga = 4'd6;
        cfg_valid = 1'b1;
        do_frame(7'd20, 4'd4, 7'd30, 4'd6, 77, 0, 0, 0, 1'b0, 8'd0, 8'd0, 10, 1, 0, 7'd0);
        @(negedge CLK);
        chk("red_final_stop_vec", 32'(cur_vec()), 32'(mk(1'b0, 1'b0, 7'd20, 4'd4, 1'b1, 1'b0, 1'b0)));
        chk("red_final_stop_val", 32'(RED_ADC_Value), 32'd77);
        @(negedge CLK);
        chk("red_final_idle", 32'(cur_vec()), 32'(mk(1'b0, 1'b0, 7'd20, 4'd4, 1'b0, 1'b0, 1'b0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_slot_scheduler.md
# led_slot_scheduler

Run-time LED/ADC time-slot scheduler for the pulse-oximeter front end; takes over once calibration has found per-channel DC compensation and PGA gain. Alternates RED and IR illumination in fixed frames and drives `DC_Comp`/`PGA_Gain` with the active channel's settings. Blanks the ADC during an analog settle window, then averages a power-of-two burst of ADC samples per slot. Publishes one averaged value per channel per frame with a valid strobe.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles per slot after LED/gain switch during which ADC is ignored (≥1).
- `SAMPLE_LOG2`, default 3: log2 of samples averaged per slot (N = 2^SAMPLE_LOG2, 0..6).

Ports:
- `CLK` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request.
- `cfg_valid` in 1: one-cycle strobe; latches the four cfg inputs into shadow registers.
- `red_dc` in 7, `red_pga` in 4, `ir_dc` in 7, `ir_pga` in 4: calibrated settings.
- `ADC` in 8: unsigned converter output.
- `LED_RED`, `LED_IR` out 1: LED enables, never both 1.
- `DC_Comp` out 7, `PGA_Gain` out 4: active-channel analog settings.
- `RED_ADC_Value`, `IR_ADC_Value` out 8: last averaged result per channel.
- `sample_valid` out 1: one-cycle strobe, new result written.
- `sample_is_ir` out 1: qualifies `sample_valid` (0 RED, 1 IR).
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, RED_SETTLE, RED_SAMPLE, IR_SETTLE, IR_SAMPLE.
- `cfg_loaded` flag set by first `cfg_valid` after reset; shadow regs updated on every `cfg_valid` in any state.
- IDLE → RED_SETTLE when `enable`=1 and (`cfg_loaded`=1 or `cfg_valid`=1). At this frame-start edge a frame snapshot of all four settings is taken from shadow regs; if `cfg_valid` is high on the same edge, the incoming values are snapshotted (bypass). Mid-frame `cfg_valid` affects the next frame only.
- RED_SETTLE: `LED_RED`=1, `LED_IR`=0, `DC_Comp`=snap red_dc, `PGA_Gain`=snap red_pga; settle counter runs SETTLE_CYCLES cycles → RED_SAMPLE.
- RED_SAMPLE: N cycles; accumulator (8+SAMPLE_LOG2 bits, cannot overflow) cleared on entry, adds `ADC` each cycle. After Nth cycle → IR_SETTLE; `RED_ADC_Value` = acc >> SAMPLE_LOG2 (truncation, incl. final sample).
- IR_SETTLE/IR_SAMPLE: identical with IR LED/settings; result to `IR_ADC_Value`; then → RED_SETTLE with new snapshot (next frame), or IDLE if `enable`=0.
- `enable`=0 in any non-IDLE state: next edge → IDLE, LEDs off, `DC_Comp`/`PGA_Gain` hold, partial accumulation discarded, no `sample_valid`, result regs keep old values.
- Unused state encodings → IDLE.

## Timing
- Reset: state IDLE; all outputs 0; shadow/snapshot regs, counters, accumulator, `cfg_loaded` 0.
- All outputs registered. Edge E0 = frame start. Cycles 1..S (S=SETTLE_CYCLES) RED_SETTLE, S+1..S+N RED_SAMPLE (ADC captured at end of each), cycle S+N+1 first IR_SETTLE cycle with `sample_valid`=1, `sample_is_ir`=0, `RED_ADC_Value` updated. IR mirrors: `sample_valid`/`sample_is_ir`=1 in first cycle of the next frame's RED_SETTLE (or first IDLE cycle if stopping).
- Frame period 2·(S+N) cycles; LED switching and setting update on the same edge; no overlap cycle.
- Stop via `enable`=0 during the edge that would write IR result: the result is still written and strobed (write takes priority over abort only on the final sample edge); same for RED.
- Reset mid-frame: immediate asynchronous return to reset values.

## Test plan
- Reset/idle: `enable`=1 with no `cfg_valid` → stays IDLE, `busy`=0, all outputs 0.
- Basic frame (S=2,N=8): cfg red 40/5, ir 90/9, `ADC` constant 100 in RED, 200 in IR → `LED_RED` 10 cycles then `LED_IR` 10; `DC_Comp`/`PGA_Gain` 40/5 then 90/9; `RED_ADC_Value`=100 strobe at cycle 11, `IR_ADC_Value`=200 at cycle 21.
- Blanking/averaging: settle cycles `ADC`=255, samples 0..7 → result 3 (28>>3); samples all 255 → 255.
- Config timing: `cfg_valid` red_dc=60 mid-RED_SAMPLE → current frame keeps 40, next frame 60; `cfg_valid` on frame-start edge → used immediately.
- Abort: `enable`=0 at 4th RED_SAMPLE cycle → next cycle IDLE, LEDs 0, no strobe, `RED_ADC_Value` unchanged; re-enable restarts at RED_SETTLE with fresh accumulator.
- Async reset asserted mid-IR_SAMPLE → outputs 0 without clock edge; `cfg_loaded` cleared.
